// File: rtl/l2_mem_arbiter_if.sv
// Signal bundle for l2_mem_arbiter: I-cache and D-cache refill ports plus the shared memory port.
// The slave modport is the arbiter's view; master is the core/memory side.
interface l2_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  i_strobe_i;
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic [LINE_WIDTH-1:0] i_data_o;
    logic                  i_done_o;
    logic                  d_strobe_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic                  d_rw_i;
    logic [LINE_WIDTH-1:0] d_data_i;
    logic [LINE_WIDTH-1:0] d_data_o;
    logic                  d_done_o;
    logic                  m_strobe_o;
    logic [ADDR_WIDTH-1:0] m_addr_o;
    logic                  m_rw_o;
    logic [LINE_WIDTH-1:0] m_data_o;
    logic [LINE_WIDTH-1:0] m_data_i;
    logic                  m_done_i;
    logic                  busy_o;
    logic                  timeout_o;

    modport slave (
        input  i_strobe_i, i_addr_i, d_strobe_i, d_addr_i, d_rw_i, d_data_i, m_data_i, m_done_i,
        output i_data_o, i_done_o, d_data_o, d_done_o, m_strobe_o, m_addr_o, m_rw_o, m_data_o,
               busy_o, timeout_o
    );

    modport master (
        output i_strobe_i, i_addr_i, d_strobe_i, d_addr_i, d_rw_i, d_data_i, m_data_i, m_done_i,
        input  i_data_o, i_done_o, d_data_o, d_done_o, m_strobe_o, m_addr_o, m_rw_o, m_data_o,
               busy_o, timeout_o
    );
endinterface

// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache and D-cache refills,
// with one outstanding transaction at a time and a watchdog on every memory wait.
module l2_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    l2_mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  i_pend_q, i_pend_d;
    logic                  d_pend_q, d_pend_d;
    logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d;
    logic [ADDR_WIDTH-1:0] d_addr_q, d_addr_d;
    logic                  d_rw_q, d_rw_d;
    logic [LINE_WIDTH-1:0] d_wdata_q, d_wdata_d;
    logic                  m_strobe_q, m_strobe_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic                  m_rw_q, m_rw_d;
    logic [LINE_WIDTH-1:0] m_data_q, m_data_d;
    logic [LINE_WIDTH-1:0] i_data_q, i_data_d;
    logic [LINE_WIDTH-1:0] d_data_q, d_data_d;
    logic                  i_done_q, i_done_d;
    logic                  d_done_q, d_done_d;
    logic                  busy_q, busy_d;
    logic                  timeout_q, timeout_d;

    logic                  i_clr_s, d_clr_s, i_take_s, d_take_s;
    logic                  gnt_s, rsp_s;
    logic [LINE_WIDTH-1:0] rsp_data_s;

    // Request capture: a strobe landing in its own RESP cycle wins over the clear.
    always_comb begin
        i_clr_s   = (state_q == S_RESP) && (grant_q == GNT_I);
        d_clr_s   = (state_q == S_RESP) && (grant_q == GNT_D);
        i_take_s  = bus.i_strobe_i && (!i_pend_q || i_clr_s);
        d_take_s  = bus.d_strobe_i && (!d_pend_q || d_clr_s);
        i_pend_d  = i_pend_q;
        i_addr_d  = i_addr_q;
        d_pend_d  = d_pend_q;
        d_addr_d  = d_addr_q;
        d_rw_d    = d_rw_q;
        d_wdata_d = d_wdata_q;
        if (i_take_s) begin
            i_pend_d = 1'b1;
            i_addr_d = bus.i_addr_i;
        end else if (i_clr_s) begin
            i_pend_d = 1'b0;
        end else begin
            i_pend_d = i_pend_q;
        end
        if (d_take_s) begin
            d_pend_d  = 1'b1;
            d_addr_d  = bus.d_addr_i;
            d_rw_d    = bus.d_rw_i;
            d_wdata_d = bus.d_data_i;
        end else if (d_clr_s) begin
            d_pend_d = 1'b0;
        end else begin
            d_pend_d = d_pend_q;
        end
    end

    // Transaction sequencing, memory-side drive and response delivery.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wd_d         = wd_q;
        m_strobe_d   = 1'b0;
        m_addr_d     = m_addr_q;
        m_rw_d       = m_rw_q;
        m_data_d     = m_data_q;
        i_data_d     = i_data_q;
        d_data_d     = d_data_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        timeout_d    = timeout_q;
        rsp_s        = 1'b0;
        rsp_data_s   = '0;
        gnt_s        = (i_pend_q && d_pend_q) ? ~last_grant_q : d_pend_q;
        case (state_q)
            S_IDLE: begin
                if (i_pend_q || d_pend_q) begin
                    state_d    = S_ISSUE;
                    grant_d    = gnt_s;
                    m_strobe_d = 1'b1;
                    if (gnt_s == GNT_D) begin
                        m_addr_d = d_addr_q;
                        m_rw_d   = d_rw_q;
                        m_data_d = d_wdata_q;
                    end else begin
                        m_addr_d = i_addr_q;
                        m_rw_d   = 1'b0;
                        m_data_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                if (bus.m_done_i) begin
                    rsp_s      = 1'b1;
                    rsp_data_s = bus.m_data_i;
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    rsp_s      = 1'b1;
                    rsp_data_s = '0;
                    timeout_d  = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
                if (rsp_s) begin
                    state_d = S_RESP;
                    if (grant_q == GNT_I) begin
                        i_done_d = 1'b1;
                        i_data_d = rsp_data_s;
                    end else begin
                        d_done_d = 1'b1;
                        if (!m_rw_q) begin
                            d_data_d = rsp_data_s;
                        end else begin
                            d_data_d = d_data_q;
                        end
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d      = S_IDLE;
                last_grant_d = grant_q;
                wd_d         = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; last_grant resets to D so the first tie goes to I.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            grant_q      <= GNT_I;
            last_grant_q <= GNT_D;
            wd_q         <= '0;
            i_pend_q     <= 1'b0;
            d_pend_q     <= 1'b0;
            i_addr_q     <= '0;
            d_addr_q     <= '0;
            d_rw_q       <= 1'b0;
            d_wdata_q    <= '0;
            m_strobe_q   <= 1'b0;
            m_addr_q     <= '0;
            m_rw_q       <= 1'b0;
            m_data_q     <= '0;
            i_data_q     <= '0;
            d_data_q     <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
            i_pend_q     <= i_pend_d;
            d_pend_q     <= d_pend_d;
            i_addr_q     <= i_addr_d;
            d_addr_q     <= d_addr_d;
            d_rw_q       <= d_rw_d;
            d_wdata_q    <= d_wdata_d;
            m_strobe_q   <= m_strobe_d;
            m_addr_q     <= m_addr_d;
            m_rw_q       <= m_rw_d;
            m_data_q     <= m_data_d;
            i_data_q     <= i_data_d;
            d_data_q     <= d_data_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.m_strobe_o = m_strobe_q;
    assign bus.m_addr_o   = m_addr_q;
    assign bus.m_rw_o     = m_rw_q;
    assign bus.m_data_o   = m_data_q;
    assign bus.i_data_o   = i_data_q;
    assign bus.i_done_o   = i_done_q;
    assign bus.d_data_o   = d_data_q;
    assign bus.d_done_o   = d_done_q;
    assign bus.busy_o     = busy_q;
    assign bus.timeout_o  = timeout_q;
endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Self-checking bench for l2_mem_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction/latency model of the arbiter.
module tb_l2_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int TO = 8;

    localparam logic [LW-1:0] LINE_AA = {8{32'hAAAA_AAAA}};
    localparam logic [LW-1:0] LINE_55 = {8{32'h5555_5555}};
    localparam logic [LW-1:0] LINE_B  = {8{32'hC3C3_5A5A}};
    localparam logic [LW-1:0] LINE_C  = {8{32'h0F1E_2D3C}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    l2_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory responder: -1 never answers, -2 random delay 1..10, else fixed delay in cycles.
    int            mem_delay = 1;
    bit            mem_rand  = 1'b0;
    logic [LW-1:0] mem_data  = '0;
    int            cd        = 0;

    initial begin
        bus.m_done_i = 1'b0;
        bus.m_data_i = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.m_done_i = 1'b0;
            if (bus.m_strobe_o) begin
                if (mem_delay == -1)      cd = 0;
                else if (mem_delay == -2) cd = $urandom_range(10, 1);
                else                      cd = mem_delay;
            end else if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    bus.m_done_i = 1'b1;
                    bus.m_data_i = mem_rand ? rand_line() : mem_data;
                end
            end
        end
    end

    // Reference model: pending requests, round-robin choice and latency arithmetic.
    int            mc, t_iss, t_rsp, stb_cnt;
    bit            ip, dp, drw, lg, act, tp, trw, clr_i, clr_d;
    logic [AW-1:0] ia, da, e_maddr;
    logic [LW-1:0] dwd, e_mdata, e_idata, e_ddata;
    bit            e_mstb, e_mrw, e_idone, e_ddone, e_busy, e_to;

    task automatic deliver(input logic [LW-1:0] v);
        if (!tp)       e_idata = v;
        else if (!trw) e_ddata = v;
    endtask

    initial begin
        stb_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mc = 0; t_iss = 0; t_rsp = -1;
                ip = 0; dp = 0; drw = 0; lg = 1; act = 0; tp = 0; trw = 0;
                ia = '0; da = '0; dwd = '0;
                e_maddr = '0; e_mdata = '0; e_idata = '0; e_ddata = '0;
                e_mstb = 0; e_mrw = 0; e_idone = 0; e_ddone = 0; e_busy = 0; e_to = 0;
            end else begin
                mc = mc + 1;
                e_mstb = 0; e_idone = 0; e_ddone = 0; clr_i = 0; clr_d = 0;
                if (act && t_rsp == mc - 1) begin
                    act = 0;
                    lg  = tp;
                    if (tp) clr_d = 1; else clr_i = 1;
                end else if (!act && (ip || dp)) begin
                    tp      = (ip && dp) ? !lg : dp;
                    act     = 1;
                    t_iss   = mc;
                    t_rsp   = -1;
                    e_mstb  = 1;
                    trw     = tp ? drw : 1'b0;
                    e_mrw   = trw;
                    e_maddr = tp ? da : ia;
                    e_mdata = tp ? dwd : '0;
                end else if (act && t_rsp < 0 && mc - 1 > t_iss) begin
                    if (bus.m_done_i) begin
                        t_rsp = mc;
                        deliver(bus.m_data_i);
                    end else if (mc == t_iss + TO + 1) begin
                        t_rsp = mc;
                        e_to  = 1;
                        deliver('0);
                    end
                end
                if (act && t_rsp == mc) begin
                    if (tp) e_ddone = 1; else e_idone = 1;
                end
                if (bus.i_strobe_i && (!ip || clr_i)) begin
                    ip = 1; ia = bus.i_addr_i;
                end else if (clr_i) begin
                    ip = 0;
                end
                if (bus.d_strobe_i && (!dp || clr_d)) begin
                    dp = 1; da = bus.d_addr_i; drw = bus.d_rw_i; dwd = bus.d_data_i;
                end else if (clr_d) begin
                    dp = 0;
                end
                e_busy = act;
            end
            check_val("m_strobe", bus.m_strobe_o, e_mstb);
            check_val("m_addr",   bus.m_addr_o,   e_maddr);
            check_val("m_rw",     bus.m_rw_o,     e_mrw);
            check_val("m_data",   bus.m_data_o,   e_mdata);
            check_val("i_done",   bus.i_done_o,   e_idone);
            check_val("d_done",   bus.d_done_o,   e_ddone);
            check_val("i_data",   bus.i_data_o,   e_idata);
            check_val("d_data",   bus.d_data_o,   e_ddata);
            check_val("busy",     bus.busy_o,     e_busy);
            check_val("timeout",  bus.timeout_o,  e_to);
            if (bus.m_strobe_o) stb_cnt = stb_cnt + 1;
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic i_req(input logic [AW-1:0] a);
        bus.i_strobe_i = 1'b1;
        bus.i_addr_i   = a;
        next_cycle();
        bus.i_strobe_i = 1'b0;
    endtask

    task automatic d_req(input logic [AW-1:0] a, input logic rw, input logic [LW-1:0] wd);
        bus.d_strobe_i = 1'b1;
        bus.d_addr_i   = a;
        bus.d_rw_i     = rw;
        bus.d_data_i   = wd;
        next_cycle();
        bus.d_strobe_i = 1'b0;
    endtask

    // Returns 0 for an I completion, 1 for D, and the number of cycles waited.
    task automatic wait_done(output int port, output int ncyc);
        port = -1;
        ncyc = 0;
        for (int k = 0; k < 40 && port < 0; k++) begin
            next_cycle();
            ncyc++;
            if (bus.i_done_o)      port = 0;
            else if (bus.d_done_o) port = 1;
        end
        if (port < 0) check_val("done_seen", bus.i_done_o | bus.d_done_o, 1'b1);
    endtask

    int port, ncyc, s0, exp_port;

    initial begin
        bus.i_strobe_i = 1'b0; bus.i_addr_i = '0;
        bus.d_strobe_i = 1'b0; bus.d_addr_i = '0; bus.d_rw_i = 1'b0; bus.d_data_i = '0;
        repeat (3) next_cycle();
        check_val("rst_busy", bus.busy_o, 1'b0);
        check_val("rst_idata", bus.i_data_o, '0);
        rst = 1'b0;
        repeat (5) next_cycle();

        // Single I read, memory answers three cycles after the issue.
        mem_delay = 3; mem_data = LINE_AA;
        i_req(32'h0000_1000);
        next_cycle();
        check_val("s1_strobe", bus.m_strobe_o, 1'b1);
        check_val("s1_addr", bus.m_addr_o, 32'h0000_1000);
        wait_done(port, ncyc);
        check_val("s1_port", port, 0);
        check_val("s1_lat", ncyc, 4);
        check_val("s1_idata", bus.i_data_o, LINE_AA);

        // Ties after reset go to I, then alternate.
        do_reset();
        mem_delay = 2; mem_data = LINE_B;
        bus.i_strobe_i = 1'b1; bus.i_addr_i = 32'h100;
        bus.d_strobe_i = 1'b1; bus.d_addr_i = 32'h200; bus.d_rw_i = 1'b0; bus.d_data_i = '0;
        next_cycle();
        bus.i_strobe_i = 1'b0; bus.d_strobe_i = 1'b0;
        wait_done(port, ncyc); check_val("tie1_first", port, 0);
        wait_done(port, ncyc); check_val("tie1_second", port, 1);
        bus.i_strobe_i = 1'b1; bus.d_strobe_i = 1'b1;
        next_cycle();
        bus.i_strobe_i = 1'b0; bus.d_strobe_i = 1'b0;
        wait_done(port, ncyc); check_val("tie2_first", port, 0);
        wait_done(port, ncyc); check_val("tie2_second", port, 1);
        bus.i_strobe_i = 1'b1; bus.d_strobe_i = 1'b1;
        next_cycle();
        bus.i_strobe_i = 1'b0; bus.d_strobe_i = 1'b0;
        exp_port = 0;
        for (int k = 0; k < 6; k++) begin
            wait_done(port, ncyc);
            check_val("alternate", port, exp_port);
            exp_port = 1 - exp_port;
            bus.i_strobe_i = 1'b1; bus.d_strobe_i = 1'b1;
            next_cycle();
            bus.i_strobe_i = 1'b0; bus.d_strobe_i = 1'b0;
        end
        wait_done(port, ncyc);
        wait_done(port, ncyc);
        check_val("alt_ddata", bus.d_data_o, LINE_B);

        // D writeback: write data held on the memory port, d_data_o untouched.
        mem_delay = 4; mem_data = LINE_C;
        d_req(32'h8000_0040, 1'b1, LINE_55);
        next_cycle();
        next_cycle();
        check_val("wb_rw", bus.m_rw_o, 1'b1);
        check_val("wb_mdata", bus.m_data_o, LINE_55);
        check_val("wb_maddr", bus.m_addr_o, 32'h8000_0040);
        wait_done(port, ncyc);
        check_val("wb_port", port, 1);
        check_val("wb_ddata", bus.d_data_o, LINE_B);

        // Watchdog: unanswered I read completes with zero data and a sticky flag.
        mem_delay = -1;
        i_req(32'h0000_3000);
        next_cycle();
        check_val("wd_issue", bus.m_strobe_o, 1'b1);
        wait_done(port, ncyc);
        check_val("wd_lat", ncyc, TO + 1);
        check_val("wd_idata", bus.i_data_o, '0);
        check_val("wd_flag", bus.timeout_o, 1'b1);
        mem_delay = 2; mem_data = LINE_AA;
        i_req(32'h0000_3040);
        wait_done(port, ncyc);
        check_val("wd_next_idata", bus.i_data_o, LINE_AA);
        check_val("wd_sticky", bus.timeout_o, 1'b1);

        // Reset while waiting on memory; the late answer must be ignored.
        mem_delay = 3;
        i_req(32'h0000_5000);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        check_val("mid_busy", bus.busy_o, 1'b0);
        check_val("mid_maddr", bus.m_addr_o, '0);
        check_val("mid_idata", bus.i_data_o, '0);
        check_val("mid_timeout", bus.timeout_o, 1'b0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            check_val("late_done", bus.i_done_o | bus.d_done_o, 1'b0);
        end

        // Re-strobe on the D done cycle, then a duplicate strobe while pending.
        mem_delay = 2; mem_data = LINE_C;
        d_req(32'h400, 1'b0, '0);
        wait_done(port, ncyc);
        check_val("rs_port", port, 1);
        d_req(32'h440, 1'b0, '0);
        next_cycle();
        check_val("rs_strobe", bus.m_strobe_o, 1'b1);
        check_val("rs_addr", bus.m_addr_o, 32'h440);
        wait_done(port, ncyc);
        repeat (2) next_cycle();
        s0 = stb_cnt;
        d_req(32'h480, 1'b0, '0);
        d_req(32'h4C0, 1'b0, '0);
        check_val("dup_addr", bus.m_addr_o, 32'h480);
        wait_done(port, ncyc);
        repeat (6) next_cycle();
        check_val("dup_count", stb_cnt - s0, 1);

        // Random traffic with random memory latency, including timeouts.
        do_reset();
        mem_delay = -2; mem_rand = 1'b1;
        for (int k = 0; k < 400; k++) begin
            bus.i_strobe_i = ($urandom_range(3, 0) == 0);
            bus.i_addr_i   = $urandom & 32'hFFFF_FFE0;
            bus.d_strobe_i = ($urandom_range(3, 0) == 0);
            bus.d_addr_i   = $urandom & 32'hFFFF_FFE0;
            bus.d_rw_i     = $urandom_range(1, 0);
            bus.d_data_i   = rand_line();
            next_cycle();
        end
        bus.i_strobe_i = 1'b0; bus.d_strobe_i = 1'b0;
        repeat (40) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish in time");
        $fatal(1);
    end
endmodule
